// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: funct3 access-width codes and the LSU state encoding.
// No ports; imported by rv32i_lsu and rv32i_lsu_align.
package rv32i_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    LSU_IDLE = 2'd0,
    LSU_REQ  = 2'd1,
    LSU_RESP = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/rv32i_lsu_align.sv
// Combinational byte-lane logic for the LSU.
// Request side (live inputs): access fault check, store strobe and data replication.
// Response side (latched request): load lane selection and sign/zero extension.
// Ports:
//   is_load_i, is_store_i, funct3_i, off_i, store_data_i -> fault_o, wstrb_o, wdata_o
//   ld_funct3_i, ld_off_i, rdata_i                       -> load_data_o
module rv32i_lsu_align
  import rv32i_pkg::*;
(
  input  logic        is_load_i,
  input  logic        is_store_i,
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] store_data_i,
  output logic        fault_o,
  output logic [3:0]  wstrb_o,
  output logic [31:0] wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_off_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] load_data_o
);

  // Fault check; illegal width codes fault like misaligned accesses. Load wins if both flags set.
  always_comb begin
    fault_o = 1'b0;
    if (is_load_i) begin
      unique case (funct3_i)
        F3_LB, F3_LBU: fault_o = 1'b0;
        F3_LH, F3_LHU: fault_o = off_i[0];
        F3_LW:         fault_o = (off_i != 2'b00);
        default:       fault_o = 1'b1;
      endcase
    end else if (is_store_i) begin
      unique case (funct3_i)
        F3_SB:   fault_o = 1'b0;
        F3_SH:   fault_o = off_i[0];
        F3_SW:   fault_o = (off_i != 2'b00);
        default: fault_o = 1'b1;
      endcase
    end
  end

  // Store lane steering: data replicated across lanes, strobe picks the lanes.
  always_comb begin
    wstrb_o = 4'b0000;
    wdata_o = store_data_i;
    unique case (funct3_i)
      F3_SB: begin
        wstrb_o = 4'b0001 << off_i;
        wdata_o = {4{store_data_i[7:0]}};
      end
      F3_SH: begin
        wstrb_o = 4'b0011 << {off_i[1], 1'b0};
        wdata_o = {2{store_data_i[15:0]}};
      end
      F3_SW: begin
        wstrb_o = 4'hF;
        wdata_o = store_data_i;
      end
      default: begin
        wstrb_o = 4'b0000;
        wdata_o = store_data_i;
      end
    endcase
  end

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // Load lane selection and extension.
  always_comb begin
    unique case (ld_off_i)
      2'd0:    ld_byte = rdata_i[7:0];
      2'd1:    ld_byte = rdata_i[15:8];
      2'd2:    ld_byte = rdata_i[23:16];
      default: ld_byte = rdata_i[31:24];
    endcase
    ld_half = ld_off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    unique case (ld_funct3_i)
      F3_LB:   load_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_LBU:  load_data_o = {24'h000000, ld_byte};
      F3_LH:   load_data_o = {{16{ld_half[15]}}, ld_half};
      F3_LHU:  load_data_o = {16'h0000, ld_half};
      F3_LW:   load_data_o = rdata_i;
      default: load_data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/rv32i_lsu.sv
// RV32I load/store unit: runs one data-memory transaction per start pulse over a
// req/ack bus, holding the stage controller via busy until the done pulse.
// Optional macro RV32I_LSU_TIMEOUT_EN: abort REQ after TIMEOUT_CYCLES cycles with bus_err.
// Ports:
//   clk, rst (sync, active-high)
//   start, is_load, is_store, funct3, addr, store_data      : request from controller
//   mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb          : bus request
//   mem_ack, mem_rdata                                       : bus response
//   busy, done, load_data, misaligned, bus_err               : status/result to controller
module rv32i_lsu
  import rv32i_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_err
);

  lsu_state_e  state_q;
  logic        mem_req_q;
  logic        mem_we_q;
  logic [31:0] mem_addr_q;
  logic [31:0] mem_wdata_q;
  logic [3:0]  mem_wstrb_q;
  logic        busy_q;
  logic        done_q;
  logic [31:0] load_data_q;
  logic        misaligned_q;
  logic        ld_q;
  logic [2:0]  ld_funct3_q;
  logic [1:0]  ld_off_q;

  logic        fault;
  logic [3:0]  st_wstrb;
  logic [31:0] st_wdata;
  logic [31:0] ld_ext;

  rv32i_lsu_align u_align (
    .is_load_i    (is_load),
    .is_store_i   (is_store),
    .funct3_i     (funct3),
    .off_i        (addr[1:0]),
    .store_data_i (store_data),
    .fault_o      (fault),
    .wstrb_o      (st_wstrb),
    .wdata_o      (st_wdata),
    .ld_funct3_i  (ld_funct3_q),
    .ld_off_i     (ld_off_q),
    .rdata_i      (mem_rdata),
    .load_data_o  (ld_ext)
  );

`ifdef RV32I_LSU_TIMEOUT_EN
  localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                  $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CNT_W-1:0] cnt_q;
  logic             bus_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  // Transaction FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LSU_IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 32'h0;
      mem_wdata_q  <= 32'h0;
      mem_wstrb_q  <= 4'h0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      load_data_q  <= 32'h0;
      misaligned_q <= 1'b0;
      ld_q         <= 1'b0;
      ld_funct3_q  <= 3'b000;
      ld_off_q     <= 2'b00;
`ifdef RV32I_LSU_TIMEOUT_EN
      cnt_q        <= '0;
      bus_err_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        LSU_IDLE: begin
          if (start) begin
            if (!is_load && !is_store) begin
              // Non-memory instruction: complete immediately, no bus cycle.
              state_q <= LSU_RESP;
              done_q  <= 1'b1;
            end else if (fault) begin
              state_q      <= LSU_RESP;
              done_q       <= 1'b1;
              misaligned_q <= 1'b1;
            end else begin
              state_q     <= LSU_REQ;
              mem_req_q   <= 1'b1;
              busy_q      <= 1'b1;
              mem_we_q    <= ~is_load;
              mem_addr_q  <= {addr[31:2], 2'b00};
              mem_wdata_q <= st_wdata;
              mem_wstrb_q <= is_load ? 4'h0 : st_wstrb;
              ld_q        <= is_load;
              ld_funct3_q <= funct3;
              ld_off_q    <= addr[1:0];
`ifdef RV32I_LSU_TIMEOUT_EN
              cnt_q       <= '0;
`endif
            end
          end
        end
        LSU_REQ: begin
          if (mem_ack) begin
            state_q   <= LSU_RESP;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            if (ld_q) load_data_q <= ld_ext;
          end
`ifdef RV32I_LSU_TIMEOUT_EN
          // Ack takes priority over a timeout in the same cycle.
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q   <= LSU_RESP;
            mem_req_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            bus_err_q <= 1'b1;
            if (ld_q) load_data_q <= 32'h0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
`endif
        end
        LSU_RESP: begin
          state_q      <= LSU_IDLE;
          done_q       <= 1'b0;
          misaligned_q <= 1'b0;
`ifdef RV32I_LSU_TIMEOUT_EN
          bus_err_q    <= 1'b0;
`endif
        end
        default: state_q <= LSU_IDLE;
      endcase
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_wstrb  = mem_wstrb_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign load_data  = load_data_q;
  assign misaligned = misaligned_q;
`ifdef RV32I_LSU_TIMEOUT_EN
  assign bus_err    = bus_err_q;
`else
  assign bus_err    = 1'b0;
`endif

endmodule

// File: tb/tb_rv32i_lsu.sv
// Directed self-checking bench for rv32i_lsu.
module tb_rv32i_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv32i_lsu #(
`ifdef RV32I_LSU_TIMEOUT_EN
    .TIMEOUT_CYCLES(4)
`else
    .TIMEOUT_CYCLES(255)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .is_load    (is_load),
    .is_store   (is_store),
    .funct3     (funct3),
    .addr       (addr),
    .store_data (store_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_wstrb  (mem_wstrb),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .busy       (busy),
    .done       (done),
    .load_data  (load_data),
    .misaligned (misaligned),
    .bus_err    (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start for one cycle; returns in cycle T+1.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd);
    is_load = ld; is_store = st; funct3 = f3; addr = a; store_data = sd;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Load acked on its first REQ cycle; checks done at T+2 and the result.
  task automatic load_ack(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rd, input logic [31:0] exp);
    issue(1'b1, 1'b0, f3, a, 32'h0);
    chk({tag, "_req"}, 32'(mem_req), 32'd1);
    chk({tag, "_addr"}, mem_addr, {a[31:2], 2'b00});
    mem_ack = 1'b1; mem_rdata = rd;
    tick();
    mem_ack = 1'b0;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_data"}, load_data, exp);
    tick();
    chk({tag, "_done_clr"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; is_load = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = 32'h0; store_data = 32'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'h0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_ld", load_data, 32'h0);
    chk("rst_mis", 32'(misaligned), 32'd0);
    chk("rst_berr", 32'(bus_err), 32'd0);

    // LW, minimum latency
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0);
    chk("lw_req", 32'(mem_req), 32'd1);
    chk("lw_busy", 32'(busy), 32'd1);
    chk("lw_we", 32'(mem_we), 32'd0);
    chk("lw_addr", mem_addr, 32'h100);
    chk("lw_done_early", 32'(done), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick();
    mem_ack = 1'b0;
    chk("lw_done", 32'(done), 32'd1);
    chk("lw_req_drop", 32'(mem_req), 32'd0);
    chk("lw_busy_drop", 32'(busy), 32'd0);
    chk("lw_data", load_data, 32'hDEADBEEF);
    chk("lw_mis", 32'(misaligned), 32'd0);
    tick();
    chk("lw_done_pulse", 32'(done), 32'd0);

    // Byte/half extraction
    load_ack("lb", 3'b000, 32'h103, 32'h80FF0000, 32'hFFFFFF80);
    load_ack("lbu", 3'b100, 32'h103, 32'h80FF0000, 32'h00000080);
    load_ack("lh", 3'b001, 32'h102, 32'h80FF0000, 32'hFFFF80FF);
    load_ack("lhu", 3'b101, 32'h100, 32'h80FF8001, 32'h00008001);

    // SB with 3 wait cycles; a stray start mid-transaction must be ignored
    issue(1'b0, 1'b1, 3'b000, 32'h21, 32'h12345678);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("sb_req%0d", i), 32'(mem_req), 32'd1);
      chk($sformatf("sb_strb%0d", i), 32'(mem_wstrb), 32'h2);
      chk($sformatf("sb_wdata%0d", i), mem_wdata, 32'h78787878);
      chk($sformatf("sb_addr%0d", i), mem_addr, 32'h20);
      chk($sformatf("sb_we%0d", i), 32'(mem_we), 32'd1);
      if (i == 1) begin
        is_load = 1'b1; is_store = 1'b0; funct3 = 3'b010; addr = 32'h400;
        store_data = 32'hFFFFFFFF; start = 1'b1;
      end
      tick();
      start = 1'b0;
    end
    chk("sb_req3", 32'(mem_req), 32'd1);
    chk("sb_addr_stable", mem_addr, 32'h20);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sb_req_drop", 32'(mem_req), 32'd0);
    chk("sb_done", 32'(done), 32'd1);
    chk("sb_ld_keep", load_data, 32'h00008001);
    tick();
    chk("sb_idle_done", 32'(done), 32'd0);

    // SH upper half
    issue(1'b0, 1'b1, 3'b001, 32'h22, 32'h0000ABCD);
    chk("sh_strb", 32'(mem_wstrb), 32'hC);
    chk("sh_wdata", mem_wdata, 32'hABCDABCD);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("sh_done", 32'(done), 32'd1);
    tick();

    // Misaligned SW
    issue(1'b0, 1'b1, 3'b010, 32'h22, 32'h0);
    chk("sw_mis_done", 32'(done), 32'd1);
    chk("sw_mis_flag", 32'(misaligned), 32'd1);
    chk("sw_mis_req", 32'(mem_req), 32'd0);
    chk("sw_mis_busy", 32'(busy), 32'd0);
    tick();
    chk("sw_mis_clr", 32'(misaligned), 32'd0);
    chk("sw_mis_req2", 32'(mem_req), 32'd0);

    // Illegal load funct3 faults as misaligned
    issue(1'b1, 1'b0, 3'b011, 32'h100, 32'h0);
    chk("ill_done", 32'(done), 32'd1);
    chk("ill_mis", 32'(misaligned), 32'd1);
    chk("ill_ld_keep", load_data, 32'h00008001);
    tick();

    // Non-memory op
    issue(1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    chk("nop_done", 32'(done), 32'd1);
    chk("nop_mis", 32'(misaligned), 32'd0);
    chk("nop_berr", 32'(bus_err), 32'd0);
    chk("nop_busy", 32'(busy), 32'd0);
    tick();

    // Stray ack while idle
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_done", 32'(done), 32'd0);
    chk("idle_ack_req", 32'(mem_req), 32'd0);

    // Reset during REQ, late ack must not complete anything
    issue(1'b1, 1'b0, 3'b010, 32'h200, 32'h0);
    chk("rr_req", 32'(mem_req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rr_req_low", 32'(mem_req), 32'd0);
    chk("rr_busy_low", 32'(busy), 32'd0);
    chk("rr_done", 32'(done), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h55555555;
    tick();
    mem_ack = 1'b0;
    chk("rr_late_done", 32'(done), 32'd0);
    chk("rr_ld", load_data, 32'h0);
    tick();
    chk("rr_late_done2", 32'(done), 32'd0);
    load_ack("rr_lw", 3'b010, 32'h104, 32'h0BADF00D, 32'h0BADF00D);

`ifdef RV32I_LSU_TIMEOUT_EN
    // Timeout: no ack for 4 REQ cycles
    issue(1'b1, 1'b0, 3'b010, 32'h300, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("to_req%0d", i), 32'(mem_req), 32'd1);
      chk($sformatf("to_done%0d", i), 32'(done), 32'd0);
      tick();
    end
    chk("to_req_drop", 32'(mem_req), 32'd0);
    chk("to_done", 32'(done), 32'd1);
    chk("to_berr", 32'(bus_err), 32'd1);
    chk("to_ld", load_data, 32'h0);
    tick();
    chk("to_berr_clr", 32'(bus_err), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32i_lsu.md
# rv32i_lsu

Load/store unit for the unpipelined RV32I core, sitting directly downstream of the core's stage controller. It is started in the MEMORYACCESS stage, runs one data-memory transaction over a request/acknowledge bus, and holds the controller in that stage via `busy` until `done`. It steers byte lanes for stores and sign- or zero-extends loads.

## Interface
- `TIMEOUT_CYCLES`, default 255: cycles `mem_req` may wait for `mem_ack` before aborting. Used only with `RV32I_LSU_TIMEOUT_EN`.
- `clk  in  1`: clock, rising edge.
- `rst  in  1`: reset. One clock; reset is synchronous and active-high.
- `start  in  1`: single-cycle pulse from the controller in MEMORYACCESS.
- `is_load  in  1`: current instruction is a load opcode.
- `is_store  in  1`: current instruction is a store opcode.
- `funct3  in  3`: access width and signedness.
- `addr  in  32`: ALU result, the byte address.
- `store_data  in  32`: rs2 value.
- `mem_req  out  1`: bus request, held until acknowledged.
- `mem_we  out  1`: 1 for a store.
- `mem_addr  out  32`: word-aligned address, `{addr[31:2],2'b00}`.
- `mem_wdata  out  32`: lane-replicated store data.
- `mem_wstrb  out  4`: byte enables.
- `mem_ack  in  1`: transaction complete; `mem_rdata` is valid in the same cycle.
- `mem_rdata  in  32`: read word.
- `busy  out  1`: a transaction is outstanding.
- `done  out  1`: one-cycle completion pulse.
- `load_data  out  32`: extended load result for writeback.
- `misaligned  out  1`: fault flag, valid with `done`.
- `bus_err  out  1`: timeout fault, valid with `done`.

## Operation
- States:
  - IDLE: wait for `start`.
  - REQ: `mem_req` high.
  - RESP: emit `done`, then go to IDLE.
- IDLE with `start`:
  - Neither `is_load` nor `is_store`: go to RESP with no bus activity.
  - Misaligned access: go to RESP with `misaligned`=1 and no bus activity. Misaligned means halfword with `addr[0]`=1, or word with `addr[1:0]`≠0.
  - Illegal funct3 (load 3/6/7, store >2): treated as misaligned.
  - Otherwise: latch all request fields and go to REQ.
- REQ with `mem_ack`:
  - Capture the extended `mem_rdata` into `load_data` for loads.
  - Drop `mem_req` and go to RESP.
- Store lanes:
  - SB: `wstrb` = `1<<addr[1:0]`, `wdata` = byte replicated ×4.
  - SH: `wstrb` = `4'b0011<<(2*addr[1])`, `wdata` = halfword replicated ×2.
  - SW: `wstrb` = `4'hF`.
- Load extraction:
  - LB/LBU: select lane `addr[1:0]`, sign- or zero-extend.
  - LH/LHU: select half `addr[1]`, sign- or zero-extend.
  - LW: whole word.
- `load_data` holds its value until the next completed load. Stores, faults, and non-memory ops leave it unchanged; a bus_err load sets it to 0.
- `start` while not IDLE is ignored.
- `mem_ack` outside REQ is ignored.

## Timing
- Reset values: state IDLE, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `mem_wstrb`=0, `busy`=0, `done`=0, `load_data`=0, `misaligned`=0, `bus_err`=0.
- All outputs are registered.
- Sequence for `start` at cycle T:
  - `mem_req`/`busy` rise at T+1.
  - If `mem_ack` is sampled high at cycle A ≥ T+1, `mem_req`/`busy` fall at A+1 and `done` pulses at A+1.
  - Minimum bus latency: `done` at T+2.
- No bus access (fault or non-memory op): `done` at T+1, `busy` never asserted.
- Request fields stay stable from T+1 until `mem_ack`.
- `rst` mid-transaction: `mem_req` is low after the next edge and no `done` is issued.

## Configuration
- `RV32I_LSU_TIMEOUT_EN` defined:
  - An 8+ bit counter clears on entry to REQ and increments each REQ cycle.
  - If it reaches `TIMEOUT_CYCLES` without `mem_ack`, `mem_req` drops, `done` and `bus_err` pulse on the next cycle, and a load writes 0 to `load_data`.
  - An ack arriving in the same cycle as the timeout wins.
- Undefined: REQ waits indefinitely, and `bus_err` is tied to 0.

## Structure
- Shared package `rv32i_pkg` holds:
  - funct3 constants LB/LH/LW/LBU/LHU/SB/SH/SW.
  - The LSU state encoding.
- Sub-module `rv32i_lsu_align`: combinational store lane steering and load extraction/extension. The FSM and registers stay in `rv32i_lsu`.

## Test plan
- LW, `addr`=0x100, ack on the first REQ cycle, `rdata`=0xDEADBEEF → `mem_addr`=0x100, `done` at T+2, `load_data`=0xDEADBEEF.
- LB `addr`=0x103, `rdata`=0x80FF0000 → `load_data`=0xFFFFFF80. Same access as LBU → 0x00000080. LH `addr`=0x102 → 0xFFFF80FF.
- SB `addr`=0x21, `store_data`=0x12345678, ack after 3 wait cycles → `wstrb`=4'b0010, `wdata`=0x78787878, `mem_req` high for exactly 4 cycles.
- SW `addr`=0x22 → `done`+`misaligned` at T+1, `mem_req` never high. A non-memory `start` → `done` at T+1 with no faults.
- Reset asserted during REQ, then a late `mem_ack` → no `done`; the next LW completes normally.
- With `RV32I_LSU_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, no ack → `mem_req` drops after 4 cycles, then `done`+`bus_err`, `load_data`=0.
